// File: rtl/display_pkg.sv
// Shared constants and types for the seven-segment display scanner.
package display_pkg;

    localparam int NIBBLE_W   = 4;
    localparam int MAX_DIGITS = 16;

    // Widest anode bus supported; instances slice the low NUM_DIGITS bits.
    localparam logic [MAX_DIGITS-1:0] AN_OFF = '1;

    typedef enum logic {
        BLANK = 1'b0,
        ON    = 1'b1
    } scan_phase_t;

endpackage

// File: rtl/scan_tick_gen.sv
// Per-slot cycle counter. Its flags look one cycle ahead, so the parent can
// load registered outputs that line up with the counter's next value.
module scan_tick_gen
    import display_pkg::*;
#(
    parameter int DIV          = 1000,
    parameter int BLANK_CYCLES = 2
) (
    input  logic clk,
    input  logic rst_n,
    output logic slot_end,
    output logic in_blank
);

    localparam int TW = $clog2(DIV);
    localparam logic [TW-1:0] TICK_LAST = TW'(DIV - 1);

    logic [TW-1:0] tick_cnt;
    logic [TW-1:0] tick_nxt;
    scan_phase_t   phase_nxt;

    always_comb begin
        tick_nxt  = (tick_cnt == TICK_LAST) ? '0 : tick_cnt + 1'b1;
        phase_nxt = (32'(tick_nxt) < BLANK_CYCLES) ? BLANK : ON;
    end

    assign slot_end = (tick_nxt == TICK_LAST);
    assign in_blank = (phase_nxt == BLANK);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tick_cnt <= '0;
        end else begin
            tick_cnt <= tick_nxt;
        end
    end

endmodule

// File: rtl/display_scanner.sv
// Time-multiplexed common-anode seven-segment scanner feeding segmentDecoder.
// Values are shadowed and committed only at frame boundaries so frames never tear.
module display_scanner
    import display_pkg::*;
#(
    parameter int NUM_DIGITS   = 4,
    parameter int DIV          = 1000,
    parameter int BLANK_CYCLES = 2
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             load_valid,
    output logic                             load_ready,
    input  logic [NIBBLE_W*NUM_DIGITS-1:0]   load_value,
    input  logic                             lz_blank_en,
    output logic [NIBBLE_W-1:0]              D,
    output logic [NUM_DIGITS-1:0]            AN,
    output logic [$clog2(NUM_DIGITS)-1:0]    digit_idx,
    output logic                             frame_done
);

    localparam int IDX_W = $clog2(NUM_DIGITS);
    localparam int VW    = NIBBLE_W * NUM_DIGITS;
    localparam logic [IDX_W-1:0]      LAST_IDX   = IDX_W'(NUM_DIGITS - 1);
    localparam logic [NUM_DIGITS-1:0] AN_ALL_OFF = AN_OFF[NUM_DIGITS-1:0];

    logic [VW-1:0]         disp_reg;
    logic [VW-1:0]         pend_reg;
    logic                  pend_vld;
    logic                  slot_last;
    logic                  next_slot_end;
    logic                  next_in_blank;

    logic                  accept;
    logic                  commit;
    logic [VW-1:0]         disp_nxt;
    logic [IDX_W-1:0]      idx_nxt;
    logic                  upper_zero;
    logic                  lz_hide;
    logic [NUM_DIGITS-1:0] an_nxt;
    logic [NIBBLE_W-1:0]   d_nxt;

    scan_tick_gen #(
        .DIV          (DIV),
        .BLANK_CYCLES (BLANK_CYCLES)
    ) u_tick (
        .clk      (clk),
        .rst_n    (rst_n),
        .slot_end (next_slot_end),
        .in_blank (next_in_blank)
    );

    // Handshake: a transfer happens on any cycle with load_valid && load_ready;
    // load_ready is !pend_vld, so a held value is never overwritten or lost.
    assign load_ready = !pend_vld;

    always_comb begin
        accept   = load_valid && !pend_vld;
        commit   = frame_done && pend_vld;
        disp_nxt = commit ? pend_reg : disp_reg;
        if (!slot_last) begin
            idx_nxt = digit_idx;
        end else if (digit_idx == LAST_IDX) begin
            idx_nxt = '0;
        end else begin
            idx_nxt = digit_idx + 1'b1;
        end

        // A digit is dark when it and every more-significant nibble are zero.
        upper_zero = 1'b1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (i >= int'(idx_nxt) && disp_nxt[i*NIBBLE_W +: NIBBLE_W] != '0) begin
                upper_zero = 1'b0;
            end
        end
        lz_hide = lz_blank_en && (idx_nxt != '0) && upper_zero;

        an_nxt = (next_in_blank || lz_hide) ? AN_ALL_OFF
                                            : ~(NUM_DIGITS'(1) << idx_nxt);
        d_nxt  = disp_nxt[idx_nxt*NIBBLE_W +: NIBBLE_W];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            disp_reg   <= '0;
            pend_reg   <= '0;
            pend_vld   <= 1'b0;
            slot_last  <= 1'b0;
            digit_idx  <= '0;
            frame_done <= 1'b0;
            AN         <= AN_ALL_OFF;
            D          <= '0;
        end else begin
            disp_reg   <= disp_nxt;
            slot_last  <= next_slot_end;
            digit_idx  <= idx_nxt;
            frame_done <= next_slot_end && (idx_nxt == LAST_IDX);
            AN         <= an_nxt;
            D          <= d_nxt;
            // A load accepted on the boundary cycle waits for the next boundary.
            if (commit) begin
                pend_vld <= 1'b0;
            end else if (accept) begin
                pend_vld <= 1'b1;
                pend_reg <= load_value;
            end
        end
    end

endmodule

// File: tb/tb_display_scanner.sv
// Directed bench for display_scanner with NUM_DIGITS=4, DIV=4, BLANK_CYCLES=1.
module tb_display_scanner;

    logic        clk;
    logic        rst_n;
    logic        load_valid;
    logic        load_ready;
    logic [15:0] load_value;
    logic        lz_blank_en;
    logic [3:0]  D;
    logic [3:0]  AN;
    logic [1:0]  digit_idx;
    logic        frame_done;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int pulses = 0;

    display_scanner #(
        .NUM_DIGITS   (4),
        .DIV          (4),
        .BLANK_CYCLES (1)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .load_valid  (load_valid),
        .load_ready  (load_ready),
        .load_value  (load_value),
        .lz_blank_en (lz_blank_en),
        .D           (D),
        .AN          (AN),
        .digit_idx   (digit_idx),
        .frame_done  (frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s at cycle %0d: observed %0h expected %0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic run_to(input int target);
        while (cyc < target) step();
    endtask

    task automatic load_one(input logic [15:0] v);
        load_valid = 1'b1;
        load_value = v;
        step();
        load_valid = 1'b0;
    endtask

    // Checks the blank cycle and the first lit cycle of one digit slot.
    task automatic check_slot(input int base, input int digit,
                              input logic [3:0] d_exp, input logic [3:0] an_exp);
        run_to(base + 4 * digit);
        check($sformatf("blank_an_d%0d_f%0d", digit, base), AN, 4'hF);
        check($sformatf("blank_d_d%0d_f%0d", digit, base), D, d_exp);
        check($sformatf("idx_d%0d_f%0d", digit, base), digit_idx, digit);
        step();
        check($sformatf("on_an_d%0d_f%0d", digit, base), AN, an_exp);
        check($sformatf("on_d_d%0d_f%0d", digit, base), D, d_exp);
    endtask

    initial begin
        rst_n       = 1'b0;
        load_valid  = 1'b0;
        load_value  = '0;
        lz_blank_en = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        cyc   = 0;

        // Reset state and first frame_done pulse
        check("rst_an", AN, 4'hF);
        check("rst_d", D, 4'h0);
        check("rst_idx", digit_idx, 2'd0);
        check("rst_ready", load_ready, 1'b1);
        check("rst_fd", frame_done, 1'b0);
        while (cyc < 15) begin
            if (frame_done) pulses++;
            step();
        end
        check("early_fd", pulses, 0);
        check("fd_at_15", frame_done, 1'b1);
        check("idx_at_15", digit_idx, 2'd3);

        // Basic load of 1234
        run_to(16);
        load_one(16'h1234);
        check("ready_low_1234", load_ready, 1'b0);
        check("old_d_17", D, 4'h0);
        check("old_an_17", AN, 4'hE);
        run_to(31);
        check("fd_31", frame_done, 1'b1);
        check("ready_31", load_ready, 1'b0);
        run_to(32);
        check("ready_back_32", load_ready, 1'b1);
        check_slot(32, 0, 4'h4, 4'hE);
        check_slot(32, 1, 4'h3, 4'hD);
        check_slot(32, 2, 4'h2, 4'hB);
        check_slot(32, 3, 4'h1, 4'h7);
        run_to(46);
        check("fd_46", frame_done, 1'b0);
        run_to(47);
        check("fd_47", frame_done, 1'b1);

        // Leading-zero blanking
        run_to(48);
        lz_blank_en = 1'b1;
        load_one(16'h0050);
        check_slot(64, 0, 4'h0, 4'hE);
        check_slot(64, 1, 4'h5, 4'hD);
        check_slot(64, 2, 4'h0, 4'hF);
        check_slot(64, 3, 4'h0, 4'hF);
        run_to(80);
        load_one(16'h0000);
        check_slot(96, 0, 4'h0, 4'hE);
        check_slot(96, 1, 4'h0, 4'hF);
        check_slot(96, 2, 4'h0, 4'hF);
        check_slot(96, 3, 4'h0, 4'hF);

        // Back-pressure: 5555 held while AAAA is pending
        run_to(112);
        lz_blank_en = 1'b0;
        load_one(16'hAAAA);
        check("ready_low_aaaa", load_ready, 1'b0);
        load_valid = 1'b1;
        load_value = 16'h5555;
        run_to(127);
        check("fd_127", frame_done, 1'b1);
        check("ready_127", load_ready, 1'b0);
        run_to(128);
        check("ready_back_128", load_ready, 1'b1);
        check("blank_an_d0_f128", AN, 4'hF);
        check("blank_d_d0_f128", D, 4'hA);
        step();
        load_valid = 1'b0;
        check("ready_low_5555", load_ready, 1'b0);
        check("on_an_d0_f128", AN, 4'hE);
        check("on_d_d0_f128", D, 4'hA);
        check_slot(128, 1, 4'hA, 4'hD);
        check_slot(128, 3, 4'hA, 4'h7);
        check_slot(144, 0, 4'h5, 4'hE);
        check_slot(144, 3, 4'h5, 4'h7);

        // Load accepted on the boundary cycle
        run_to(159);
        check("fd_159", frame_done, 1'b1);
        check("ready_159", load_ready, 1'b1);
        load_one(16'h00F0);
        check("ready_low_00f0", load_ready, 1'b0);
        check_slot(160, 0, 4'h5, 4'hE);
        check_slot(160, 2, 4'h5, 4'hB);
        check_slot(176, 0, 4'h0, 4'hE);
        check_slot(176, 1, 4'hF, 4'hD);
        check_slot(176, 2, 4'h0, 4'hB);
        check_slot(176, 3, 4'h0, 4'h7);

        // Asynchronous reset during digit 2's lit phase with a value pending
        run_to(192);
        load_one(16'h1234);
        run_to(201);
        check("pre_rst_an", AN, 4'hB);
        check("pre_rst_d", D, 4'h0);
        check("pre_rst_idx", digit_idx, 2'd2);
        check("pre_rst_ready", load_ready, 1'b0);
        rst_n = 1'b0;
        #1;
        check("async_an", AN, 4'hF);
        check("async_ready", load_ready, 1'b1);
        check("async_idx", digit_idx, 2'd0);
        check("async_d", D, 4'h0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        cyc   = 0;
        check("rel_an", AN, 4'hF);
        check("rel_idx", digit_idx, 2'd0);
        run_to(1);
        check("rel_on_an", AN, 4'hE);
        check("rel_on_d", D, 4'h0);
        run_to(15);
        check("rel_fd_15", frame_done, 1'b1);
        check_slot(16, 0, 4'h0, 4'hE);
        check_slot(16, 1, 4'h0, 4'hD);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/display_scanner.md
# display_scanner

Time-multiplexed driver for a common-anode multi-digit seven-segment display. It sits directly upstream of `segmentDecoder`. It latches a packed hex value through a valid/ready handshake and scans the digits one at a time. For each digit it presents that digit's 4-bit nibble to the decoder's `D` input and drives the matching active-low anode enable. New values are committed only at frame boundaries, so a displayed frame never tears.

## Interface
- `NUM_DIGITS`, 4: number of digits scanned; ≥2.
- `DIV`, 1000: clock cycles per digit slot; ≥2.
- `BLANK_CYCLES`, 2: anti-ghosting guard at the start of each slot, with all anodes off; 0 ≤ `BLANK_CYCLES` < `DIV`.

Ports (one clock; reset is asynchronous and active-low):
- `clk` in 1: sole clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `load_valid` in 1: `load_value` is valid this cycle.
- `load_ready` out 1: block can accept a value.
- `load_value` in 4*`NUM_DIGITS`: packed nibbles; digit 0 is `[3:0]`, the least significant.
- `lz_blank_en` in 1: leading-zero blanking enable; sampled every cycle.
- `D` out 4: nibble for the current digit; connects to `segmentDecoder.D`.
- `AN` out `NUM_DIGITS`: anode enables, active-low, one-hot-low or all ones.
- `digit_idx` out $clog2(`NUM_DIGITS`): index of the current slot.
- `frame_done` out 1: one-cycle pulse on the last cycle of digit `NUM_DIGITS-1`'s slot.

## Operation
- **Registers:**
  - `disp_reg`: value being shown.
  - `pend_reg` and `pend_vld`: shadow value waiting for commit.
  - `tick_cnt`: 0..`DIV`-1.
  - `digit_idx`.
- **Handshake:**
  - `load_ready = !pend_vld`.
  - A transfer occurs when `load_valid && load_ready`. It captures `load_value` into `pend_reg` and sets `pend_vld`.
  - With `load_ready` = 0 the input is ignored, with no overwrite and no loss of the pending value.
- **Slot FSM**, two phases per slot:
  - BLANK while `tick_cnt < BLANK_CYCLES`; ON otherwise.
  - `tick_cnt` increments every cycle and wraps at `DIV`-1.
  - On wrap, `digit_idx` increments, wrapping from `NUM_DIGITS`-1 to 0.
- **Frame boundary**, defined as `tick_cnt == DIV-1 && digit_idx == NUM_DIGITS-1`:
  - `frame_done` = 1.
  - If `pend_vld` was set before this cycle, `disp_reg` <= `pend_reg` and `pend_vld` is cleared.
- **Simultaneous load and boundary:** a load accepted on the boundary cycle (`pend_vld` was 0) goes into `pend_reg`. It commits at the next boundary, not this one.
- **Outputs:**
  - `D` = `disp_reg` nibble[`digit_idx`].
  - `AN` = all ones in BLANK.
  - `AN` = bit `digit_idx` low in ON, unless that digit is blanked.
- **Leading-zero blanking:**
  - Applies when `lz_blank_en` = 1.
  - Digit i > 0 is blanked (its anode stays high) if nibbles i..`NUM_DIGITS`-1 of `disp_reg` are all zero.
  - Digit 0 is never blanked.
  - `D` still carries the nibble while its digit is blanked.
- **Reset values:**
  - `AN` all ones; `D` = 0; `digit_idx` = 0; `frame_done` = 0; `load_ready` = 1.
  - `disp_reg` = 0; `pend_vld` = 0; `tick_cnt` = 0.
- **Reset mid-operation:** all state is cleared immediately (asynchronously). Any pending value is discarded, and scanning restarts at digit 0, BLANK phase.

## Timing
- `D`, `AN`, `digit_idx` and `frame_done` are registered and change together on the rising edge.
- There is no combinational path from any input to any output except `load_ready` (from `pend_vld`, also a register).
- A new slot's first cycle shows its `D` with `AN` all ones when `BLANK_CYCLES` ≥ 1.
- Load-to-display latency: from the acceptance cycle to the first cycle of the next frame. Maximum is `NUM_DIGITS`*`DIV` cycles; minimum is 1 cycle, when accepted on the cycle before the boundary.
- `frame_done` period: exactly `NUM_DIGITS`*`DIV` cycles.
- `load_ready` returns high on the cycle after the committing boundary.

## Structure
- **Shared package `display_pkg`:**
  - `NIBBLE_W` = 4.
  - `AN_OFF` constant (all ones), sized from a package parameter.
  - Typedef `scan_phase_t` {BLANK, ON}.
- **Sub-module `scan_tick_gen`:** slot counter. Parameters `DIV` and `BLANK_CYCLES`; outputs `slot_end` and `in_blank`.
- The top level holds the handshake, commit, digit index, leading-zero logic and output registers.
- `segmentDecoder` is instantiated by the integrating top level, not inside this block.

## Test plan
Parameters: `NUM_DIGITS`=4, `DIV`=4, `BLANK_CYCLES`=1.
- Reset release -> `AN`=4'b1111, `D`=0, `digit_idx`=0, `load_ready`=1; `frame_done` first pulses on cycle 15 after release.
- Load 16'h1234 → `load_ready` falls next cycle and rises after the boundary. The next frame shows each digit for three cycles after one blank cycle: `D`=4 with `AN`=1110, then `D`=3/1101, `D`=2/1011, `D`=1/0111.
- `lz_blank_en`=1, load 16'h0050 -> digit 1 shows `D`=5/`AN`=1101 and digit 0 shows `D`=0/`AN`=1110; digits 2 and 3 keep `AN`=1111. With 16'h0000, only digit 0 lights.
- Back-pressure: load 16'hAAAA, then hold `load_valid` with 16'h5555 while `load_ready`=0. Only AAAA is displayed; 5555 is accepted on the cycle `load_ready` returns and is displayed one frame later.
- Load on boundary cycle: accept 16'h00F0 exactly when `frame_done`=1 -> the following frame still shows the old value; 00F0 appears one frame later.
- Reset mid-slot: drive `rst_n` low during digit 2's ON phase with a value pending. `AN` goes to 1111 within the same cycle (asynchronous), `load_ready`=1, and after release `disp_reg` = 0 with scanning restarting at digit 0.
